// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider controller.
// Also provides the two's complement helpers used for the sign/magnitude conversion.
package div_pkg;

   localparam int unsigned DIV_ITERATIONS = 32;
   localparam int unsigned DIV_CNT_W      = 6;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StLoad = 3'd1,
      StIter = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } div_state_e;

   function automatic logic [31:0] div_neg(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

   // -2^31 maps to 0x80000000, which is the correct unsigned magnitude.
   function automatic logic [31:0] div_abs(input logic [31:0] x);
      return x[31] ? div_neg(x) : x;
   endfunction

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider core; synchronous clear wins over enable.
// The last output flags the final core iteration.
module div_iter_counter
   import div_pkg::*;
#(
   parameter int unsigned ITERATIONS = DIV_ITERATIONS,
   parameter int unsigned CNT_W      = DIV_CNT_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign last  = (count_q == CNT_W'(ITERATIONS - 1));

endmodule

// File: rtl/div_sequencer.sv
// Controller for the shared iterative divider datapath: operand magnitudes, core load,
// iteration counting, divide-by-zero detection and quotient sign correction.
module div_sequencer
   import div_pkg::*;
#(
   parameter int unsigned ITERATIONS = DIV_ITERATIONS,
   parameter int unsigned CNT_W      = DIV_CNT_W
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy,
   output logic        core_load,
   output logic [31:0] core_dividend,
   output logic [31:0] core_divisor,
   input  logic [31:0] core_quotient
);

   div_state_e  state_q, state_d;
   logic        sign_q, sign_d;
   logic [31:0] dividend_q, dividend_d;
   logic [31:0] divisor_q, divisor_d;
   logic [31:0] result_q, result_d;
   logic        exc_q, exc_d;

   logic             cnt_last;
   logic [CNT_W-1:0] unused_iter_cnt;

   div_iter_counter #(
      .ITERATIONS (ITERATIONS),
      .CNT_W      (CNT_W)
   ) u_iter_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (state_q != StIter),
      .enable  (state_q == StIter),
      .count   (unused_iter_cnt),
      .last    (cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      result_d   = result_q;
      exc_d      = exc_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (ctrl_DIV) begin
               sign_d     = data_operandA[31] ^ data_operandB[31];
               dividend_d = div_abs(data_operandA);
               divisor_d  = div_abs(data_operandB);
               exc_d      = 1'b0;
               // A zero divisor never touches the core.
               if (data_operandB == 32'd0) begin
                  state_d  = StDone;
                  result_d = 32'd0;
                  exc_d    = 1'b1;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         StLoad: state_d = StIter;
         StIter: begin
            if (cnt_last) begin
               state_d = StFix;
            end
         end
         StFix: begin
            result_d = sign_q ? div_neg(core_quotient) : core_quotient;
            state_d  = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         sign_q     <= 1'b0;
         dividend_q <= 32'd0;
         divisor_q  <= 32'd0;
         result_q   <= 32'd0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         result_q   <= result_d;
         exc_q      <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == StDone);
   assign busy           = (state_q == StLoad) || (state_q == StIter) || (state_q == StFix);
   assign core_load      = (state_q == StLoad);
   assign core_dividend  = dividend_q;
   assign core_divisor   = divisor_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural restoring-divider datapath.
module tb_div_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ctrl_DIV;
   logic [31:0] data_operandA, data_operandB;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY, busy, core_load;
   logic [31:0] core_dividend, core_divisor, core_quotient;

   always #5 clock = ~clock;

   div_sequencer u_dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy),
      .core_load      (core_load),
      .core_dividend  (core_dividend),
      .core_divisor   (core_divisor),
      .core_quotient  (core_quotient)
   );

   // Datapath model: load {0, dividend}, then one restoring step per edge for 32 edges.
   logic [63:0] dp_q = 64'd0;
   int          dp_steps = 32;

   function automatic logic [63:0] dp_step(input logic [63:0] r, input logic [31:0] d);
      logic [64:0] s;
      s = {r, 1'b0};
      if (s[64:32] >= {1'b0, d}) begin
         s[64:32] = s[64:32] - {1'b0, d};
         s[0]     = 1'b1;
      end
      return s[63:0];
   endfunction

   always @(posedge clock) begin
      if (core_load) begin
         dp_q     <= {32'd0, core_dividend};
         dp_steps <= 0;
      end else if (dp_steps < 32) begin
         dp_q     <= dp_step(dp_q, core_divisor);
         dp_steps <= dp_steps + 1;
      end
   end
   assign core_quotient = dp_q[31:0];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int n_loads = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          rdy_cyc;
   } exp_t;
   exp_t sb[$];

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint q;
      if (b == 32'd0) return 32'd0;
      q = longint'($signed(a)) / longint'($signed(b));
      return q[31:0];
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (core_load) n_loads++;
      if (data_resultRDY) begin
         if (sb.size() == 0) begin
            check("spurious_rdy", 32'(data_resultRDY), 32'd0);
         end else begin
            e = sb.pop_front();
            check("result", data_result, e.res);
            check("exception", 32'(data_exception), 32'(e.exc));
            check("rdy_cycle", 32'(cyc), 32'(e.rdy_cyc));
         end
      end
   end

   // Called just after a negedge; returns at the next negedge (cycle of the accept edge).
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit accepted);
      exp_t e;
      ctrl_DIV      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      if (accepted) begin
         e.res     = ref_div(a, b);
         e.exc     = (b == 32'd0);
         e.rdy_cyc = cyc + 1 + ((b == 32'd0) ? 0 : 34);
         sb.push_back(e);
      end
      @(negedge clock);
      ctrl_DIV = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("done_timeout", 32'(n < 200), 32'd1);
   endtask

   task automatic skip(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   logic [31:0] tab_a[4] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
   logic [31:0] tab_b[4] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int loads0;
      int n;
      reset_n       = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      skip(3);
      check("rst_result", data_result, 32'd0);
      check("rst_outputs", {27'd0, data_exception, data_resultRDY, busy, core_load, 1'b0}, 32'd0);
      check("rst_dividend", core_dividend, 32'd0);
      check("rst_divisor", core_divisor, 32'd0);
      reset_n = 1'b1;
      skip(2);

      // Basic op with load strobe and busy checks.
      loads0 = n_loads;
      start_op(32'd100, 32'd7, 1'b1);
      check("load_busy", {30'd0, core_load, busy}, 32'd3);
      check("dividend_100", core_dividend, 32'd100);
      check("divisor_7", core_divisor, 32'd7);
      @(negedge clock);
      check("iter_busy", {30'd0, core_load, busy}, 32'd1);
      wait_done();
      check("one_load", 32'(n_loads - loads0), 32'd1);

      // Sign combinations.
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         start_op(tab_a[i], tab_b[i], 1'b1);
         check("mag_dividend", core_dividend, 32'd100);
         check("mag_divisor", core_divisor, 32'd7);
         wait_done();
      end

      // Divide by zero, then a normal op clears the exception.
      @(negedge clock);
      loads0 = n_loads;
      start_op(32'd5, 32'd0, 1'b1);
      wait_done();
      check("dbz_no_load", 32'(n_loads - loads0), 32'd0);
      @(negedge clock);
      start_op(32'd9, 32'd3, 1'b1);
      check("exc_cleared", 32'(data_exception), 32'd0);
      wait_done();

      // Width corners.
      @(negedge clock);
      start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done();
      @(negedge clock);
      start_op(32'h8000_0000, 32'd2, 1'b1);
      wait_done();

      // Re-pulse during ITER is ignored.
      @(negedge clock);
      start_op(32'd1000, 32'd10, 1'b1);
      skip(11);
      start_op(32'd77, 32'd3, 1'b0);
      check("hold_dividend", core_dividend, 32'd1000);
      check("hold_divisor", core_divisor, 32'd10);
      wait_done();

      // Back-to-back: accept in the DONE cycle.
      @(negedge clock);
      start_op(32'd50, 32'd5, 1'b1);
      n = 0;
      while (!data_resultRDY && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("b2b_rdy_timeout", 32'(n < 100), 32'd1);
      start_op(32'd60, 32'hFFFF_FFFC, 1'b1);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_done();

      // Reset mid-iteration discards the op.
      @(negedge clock);
      start_op(32'd123, 32'd4, 1'b1);
      skip(21);
      reset_n = 1'b0;
      sb.delete();
      @(negedge clock);
      check("midrst_result", data_result, 32'd0);
      check("midrst_outputs", {27'd0, data_exception, data_resultRDY, busy, core_load, 1'b0},
            32'd0);
      check("midrst_dividend", core_dividend, 32'd0);
      reset_n = 1'b1;
      skip(40);
      start_op(32'd81, 32'd9, 1'b1);
      wait_done();

      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
